// File: rtl/structural_model_pkg.sv
// Shared definitions for the registered gate bank: gate count and the
// gate index enum used to address result vectors.
package logic_pkg;

  localparam int unsigned NUM_GATES = 7;

  typedef enum logic [2:0] {
    AND  = 3'd0,
    OR   = 3'd1,
    NOT  = 3'd2,
    NAND = 3'd3,
    NOR  = 3'd4,
    XOR  = 3'd5,
    XNOR = 3'd6
  } gate_e;

endpackage

// File: rtl/structural_model_gate_cell.sv
// One-bit cell of the gate bank, built purely from gate primitives.
module gate_cell (
  input  logic a,
  input  logic b,
  output logic and_g,
  output logic or_g,
  output logic not_g,
  output logic nand_g,
  output logic nor_g,
  output logic xor_g,
  output logic xnor_g
);

  and  u_and  (and_g,  a, b);
  or   u_or   (or_g,   a, b);
  not  u_not  (not_g,  a);
  nand u_nand (nand_g, a, b);
  nor  u_nor  (nor_g,  a, b);
  xor  u_xor  (xor_g,  a, b);
  xnor u_xnor (xnor_g, a, b);

endmodule

// File: rtl/structural_model.sv
// Registered bank of seven bitwise gates: one gate_cell per bit, then a
// single load-enabled output register stage with synchronous reset.
module structural_model
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_g,
  output logic [WIDTH-1:0] or_g,
  output logic [WIDTH-1:0] not_g,
  output logic [WIDTH-1:0] nand_g,
  output logic [WIDTH-1:0] nor_g,
  output logic [WIDTH-1:0] xor_g,
  output logic [WIDTH-1:0] xnor_g
);

  logic [WIDTH-1:0] gate_res [NUM_GATES];
  logic [WIDTH-1:0] reg_res  [NUM_GATES];
  logic             valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gate_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .and_g  (gate_res[AND][i]),
      .or_g   (gate_res[OR][i]),
      .not_g  (gate_res[NOT][i]),
      .nand_g (gate_res[NAND][i]),
      .nor_g  (gate_res[NOR][i]),
      .xor_g  (gate_res[XOR][i]),
      .xnor_g (gate_res[XNOR][i])
    );
  end

  // Reset clears every result to zero, not to the gate function of zero inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      reg_res <= '{default: '0};
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        reg_res <= gate_res;
      end
    end
  end

  assign out_valid = valid_q;
  assign and_g     = reg_res[AND];
  assign or_g      = reg_res[OR];
  assign not_g     = reg_res[NOT];
  assign nand_g    = reg_res[NAND];
  assign nor_g     = reg_res[NOR];
  assign xor_g     = reg_res[XOR];
  assign xnor_g    = reg_res[XNOR];

endmodule

// File: tb/tb_structural_model.sv
// Self-checking bench for structural_model: a 1-bit and an 8-bit instance
// share clock, reset and in_valid; expectations come from the gate rules.
module tb_structural_model;
  import logic_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic       ov1, ov8;
  logic [0:0] and1, or1, not1, nand1, nor1, xor1, xnor1;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state for the 8-bit instance
  logic [7:0] m_res [NUM_GATES];
  logic       m_v;

  always #5 clk = ~clk;

  structural_model #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(ov1), .and_g(and1), .or_g(or1), .not_g(not1),
    .nand_g(nand1), .nor_g(nor1), .xor_g(xor1), .xnor_g(xnor1)
  );

  structural_model #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov8), .and_g(and8), .or_g(or8), .not_g(not8),
    .nand_g(nand8), .nor_g(nor8), .xor_g(xor8), .xnor_g(xnor8)
  );

  function automatic logic [7:0] golden(gate_e g, logic [7:0] x, logic [7:0] y);
    case (g)
      AND:     return x & y;
      OR:      return x | y;
      NOT:     return ~x;
      NAND:    return ~(x & y);
      NOR:     return ~(x | y);
      XOR:     return x ^ y;
      XNOR:    return ~(x ^ y);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] obs8(gate_e g);
    case (g)
      AND:     return and8;
      OR:      return or8;
      NOT:     return not8;
      NAND:    return nand8;
      NOR:     return nor8;
      XOR:     return xor8;
      XNOR:    return xnor8;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic obs1(gate_e g);
    case (g)
      AND:     return and1[0];
      OR:      return or1[0];
      NOT:     return not1[0];
      NAND:    return nand1[0];
      NOR:     return nor1[0];
      XOR:     return xor1[0];
      XNOR:    return xnor1[0];
      default: return 1'bx;
    endcase
  endfunction

  // Advance the model with the current inputs, then one clock edge; sample #1 later.
  task automatic tick();
    if (rst) begin
      m_v = 1'b0;
      for (int g = 0; g < NUM_GATES; g++) m_res[g] = 8'h00;
    end else begin
      m_v = in_valid;
      if (in_valid)
        for (int g = 0; g < NUM_GATES; g++) m_res[g] = golden(gate_e'(g), a8, b8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    tick();
    n_cmp++;
    if (ov1 !== 1'b0 || ov8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b/%b want 0/0", ov1, ov8);
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      n_cmp++;
      if (obs8(gate_e'(g)) !== 8'h00 || obs1(gate_e'(g)) !== 1'b0) begin
        n_err++;
        $display("FAIL reset_%s: got %h/%b want 00/0", gate_e'(g), obs8(gate_e'(g)), obs1(gate_e'(g)));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [6:0] rows [4];
    logic [6:0] r;
    // Bit 6 is AND down to bit 0 XNOR.
    rows[0] = 7'b0011101;
    rows[1] = 7'b0111010;
    rows[2] = 7'b0101010;
    rows[3] = 7'b1100001;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      a1 = k[1]; b1 = k[0];
      a8 = 8'h00; b8 = 8'h00;
      tick();
      r = rows[k];
      n_cmp++;
      if (ov1 !== 1'b1) begin
        n_err++;
        $display("FAIL tt_valid row%0d: got %b want 1", k, ov1);
      end
      for (int g = 0; g < NUM_GATES; g++) begin
        n_cmp++;
        if (obs1(gate_e'(g)) !== r[6-g]) begin
          n_err++;
          $display("FAIL tt_%s row%0d: got %b want %b", gate_e'(g), k, obs1(gate_e'(g)), r[6-g]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [6:0] held;
    held = 7'b1100001;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b0;
      a1 = 1'b0; b1 = 1'b0;
      a8 = (c == 2) ? 8'hxx : 8'h00;
      b8 = (c == 2) ? 8'hzz : 8'h00;
      tick();
      n_cmp++;
      if (ov1 !== 1'b0) begin
        n_err++;
        $display("FAIL hold_valid cyc%0d: got %b want 0", c, ov1);
      end
      for (int g = 0; g < NUM_GATES; g++) begin
        n_cmp++;
        if (obs1(gate_e'(g)) !== held[6-g]) begin
          n_err++;
          $display("FAIL hold_%s cyc%0d: got %b want %b", gate_e'(g), c, obs1(gate_e'(g)), held[6-g]);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] want [NUM_GATES];
    want[AND] = 8'hC0; want[OR] = 8'hFC; want[NOT] = 8'h0F; want[NAND] = 8'h3F;
    want[NOR] = 8'h03; want[XOR] = 8'h3C; want[XNOR] = 8'hC3;
    in_valid = 1'b1; a8 = 8'hF0; b8 = 8'hCC; a1 = 1'b0; b1 = 1'b0;
    tick();
    n_cmp++;
    if (ov8 !== 1'b1) begin
      n_err++;
      $display("FAIL wide_valid: got %b want 1", ov8);
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      n_cmp++;
      if (obs8(gate_e'(g)) !== want[g]) begin
        n_err++;
        $display("FAIL wide_%s: got %h want %h", gate_e'(g), obs8(gate_e'(g)), want[g]);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [6:0] r01;
    r01 = 7'b0111010;
    rst = 1'b1; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
    tick();
    n_cmp++;
    if (ov1 !== 1'b0 || ov8 !== 1'b0) begin
      n_err++;
      $display("FAIL rstpri_valid: got %b/%b want 0/0", ov1, ov8);
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      n_cmp++;
      if (obs1(gate_e'(g)) !== 1'b0 || obs8(gate_e'(g)) !== 8'h00) begin
        n_err++;
        $display("FAIL rstpri_%s: got %b/%h want 0/00", gate_e'(g), obs1(gate_e'(g)), obs8(gate_e'(g)));
      end
    end
    rst = 1'b0; in_valid = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    n_cmp++;
    if (ov1 !== 1'b1) begin
      n_err++;
      $display("FAIL rstpri_next_valid: got %b want 1", ov1);
    end
    for (int g = 0; g < NUM_GATES; g++) begin
      n_cmp++;
      if (obs1(gate_e'(g)) !== r01[6-g]) begin
        n_err++;
        $display("FAIL rstpri_next_%s: got %b want %b", gate_e'(g), obs1(gate_e'(g)), r01[6-g]);
      end
    end
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 1000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom);
      if (!in_valid && $urandom_range(0, 7) == 0) begin
        a8 = 8'hxx; b8 = 8'hxx;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      tick();
      n_cmp++;
      if (ov8 !== m_v) begin
        n_err++;
        $display("FAIL rand_valid cyc%0d: got %b want %b", c, ov8, m_v);
      end
      for (int g = 0; g < NUM_GATES; g++) begin
        n_cmp++;
        if (obs8(gate_e'(g)) !== m_res[g]) begin
          n_err++;
          $display("FAIL rand_%s cyc%0d: got %h want %h", gate_e'(g), c, obs8(gate_e'(g)), m_res[g]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    m_v = 1'b0;
    for (int g = 0; g < NUM_GATES; g++) m_res[g] = 8'h00;
    @(negedge clk);
    test_reset();
    test_truth_table();
    test_hold();
    test_wide();
    test_reset_priority();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
